// File: rtl/line_drawer_controller.sv
// Bresenham line-drawing control FSM: picks orientation, orders endpoints,
// strobes the datapath and hands one pixel at a time to the frame-buffer writer.
module line_drawer_controller #(
    parameter int W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [W-1:0]       x0,
    input  logic [W-1:0]       y0,
    input  logic [W-1:0]       x1,
    input  logic [W-1:0]       y1,
    input  logic [W-1:0]       new_x0,
    input  logic [W-1:0]       new_x1,
    input  logic [W-1:0]       result_x,
    input  logic signed [11:0] error,
    input  logic               pixel_ready,
    output logic               load_reg,
    output logic               swap_x_y,
    output logic               swap_0_1,
    output logic               prep_reg,
    output logic               load_xy,
    output logic               load_yx,
    output logic               error_gt_0,
    output logic               incr_x,
    output logic               x0_gt_x1,
    output logic               steep,
    output logic               pixel_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ORDER,
        S_PREP,
        S_PLOT,
        S_STEP,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic         steep_q, steep_d;
    logic [W-1:0] abs_dx, abs_dy;
    logic         steep_calc;
    logic         last_px;
    logic         err_pos;

    always_comb begin
        abs_dx     = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        abs_dy     = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
        steep_calc = abs_dy > abs_dx;
        x0_gt_x1   = new_x0 > new_x1;
        last_px    = result_x == new_x1;
        err_pos    = error > 12'sd0;
    end

    always_comb begin
        state_d     = state_q;
        steep_d     = steep_q;
        load_reg    = 1'b0;
        swap_x_y    = 1'b0;
        swap_0_1    = 1'b0;
        prep_reg    = 1'b0;
        load_xy     = 1'b0;
        load_yx     = 1'b0;
        error_gt_0  = 1'b0;
        incr_x      = 1'b0;
        pixel_valid = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                steep_d  = steep_calc;
                load_reg = !steep_calc;
                swap_x_y = steep_calc;
                state_d  = S_ORDER;
            end
            S_ORDER: begin
                swap_0_1 = x0_gt_x1;
                state_d  = S_PREP;
            end
            S_PREP: begin
                prep_reg = 1'b1;
                state_d  = S_PLOT;
            end
            S_PLOT: begin
                load_xy = !steep_q;
                load_yx = steep_q;
                state_d = S_STEP;
            end
            S_STEP: begin
                pixel_valid = 1'b1;
                // The error step and x advance only happen on an accepted pixel
                if (pixel_ready) begin
                    error_gt_0 = err_pos;
                    if (last_px) begin
                        state_d = S_DONE;
                    end else begin
                        incr_x  = 1'b1;
                        state_d = S_PLOT;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            steep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            steep_q <= steep_d;
        end
    end

    assign busy  = state_q != S_IDLE;
    assign steep = steep_q;

endmodule
